// File: rtl/ray_gen_stream_pkg.sv
// Shared types and arithmetic helper for the per-core primary-ray generator.
// vec3_t is sized by RAY_VEC_W; ray_gen_stream keeps VEC_W equal to it so the
// camera shadow registers can use the struct directly.
package ray_pkg;

   localparam int RAY_VEC_W = 11;
   // Operand width of the per-axis multiply-add. It must hold
   // VEC_W+DIM_W+3 bits, which the default configuration needs (27 bits).
   localparam int RAY_OP_W  = 32;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } ray_state_e;

   typedef struct packed {
      logic signed [RAY_VEC_W-1:0] x;
      logic signed [RAY_VEC_W-1:0] y;
      logic signed [RAY_VEC_W-1:0] z;
   } vec3_t;

   // One axis of the ray direction: right*dx + up*dy + dir. All operands are
   // already sign-extended to RAY_OP_W, so the sum cannot wrap.
   function automatic logic signed [RAY_OP_W-1:0] ray_dir_comp(
      input logic signed [RAY_OP_W-1:0] right,
      input logic signed [RAY_OP_W-1:0] up,
      input logic signed [RAY_OP_W-1:0] dir,
      input logic signed [RAY_OP_W-1:0] dx,
      input logic signed [RAY_OP_W-1:0] dy
   );
      ray_dir_comp = (right * dx) + (up * dy) + dir;
   endfunction

endpackage

// File: rtl/ray_gen_stream_if.sv
// Ray output stream: valid/ready handshake plus direction and pixel payload.
interface ray_gen_stream_if #(
   parameter int DIM_W = 13,
   parameter int DIR_W = 32,
   parameter int IDX_W = 2*DIM_W
);

   logic                    ray_valid;
   logic                    ray_ready;
   logic signed [DIR_W-1:0] ray_dir_x;
   logic signed [DIR_W-1:0] ray_dir_y;
   logic signed [DIR_W-1:0] ray_dir_z;
   logic [DIM_W-1:0]        pix_x;
   logic [DIM_W-1:0]        pix_y;
   logic [IDX_W-1:0]        pix_index;
   logic                    ray_last;

   modport master (
      output ray_valid, ray_dir_x, ray_dir_y, ray_dir_z,
      output pix_x, pix_y, pix_index, ray_last,
      input  ray_ready
   );

   modport slave (
      input  ray_valid, ray_dir_x, ray_dir_y, ray_dir_z,
      input  pix_x, pix_y, pix_index, ray_last,
      output ray_ready
   );

endinterface

// File: rtl/ray_gen_stream_pixel_stepper.sv
// Incremental pixel walker for one core of an interleaved array. Holds the
// current x/y/index and whether it is this core's last pixel, and exposes the
// candidate pixel (load value or next step) so the caller can compute its ray
// in the same cycle. Because the stride never exceeds the width, at most one
// row wrap happens per step, so no divider is needed.
module ray_pixel_stepper #(
   parameter int DIM_W  = 13,
   parameter int CORE_W = 4,
   parameter int IDX_W  = 2*DIM_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load,
   input  logic              step,
   input  logic [CORE_W-1:0] load_x,
   input  logic [CORE_W-1:0] stride,
   input  logic [DIM_W-1:0]  width,
   input  logic [IDX_W-1:0]  area,
   output logic [DIM_W-1:0]  pix_x,
   output logic [DIM_W-1:0]  pix_y,
   output logic [IDX_W-1:0]  pix_index,
   output logic              pix_last,
   output logic [DIM_W-1:0]  cand_x,
   output logic [DIM_W-1:0]  cand_y,
   output logic [IDX_W-1:0]  cand_index
);

   logic [DIM_W-1:0] x_r;
   logic [DIM_W-1:0] y_r;
   logic [IDX_W-1:0] idx_r;
   logic             last_r;

   logic [DIM_W:0]   sum_x_s;
   logic [DIM_W-1:0] step_x_s;
   logic [DIM_W-1:0] step_y_s;
   logic [IDX_W-1:0] step_idx_s;
   logic [DIM_W-1:0] cand_x_s;
   logic [DIM_W-1:0] cand_y_s;
   logic [IDX_W-1:0] cand_idx_s;
   logic [IDX_W:0]   last_sum_s;
   logic             cand_last_s;

   // Next pixel after one stride, the load/step candidate and its last flag.
   always_comb begin
      sum_x_s    = {1'b0, x_r} + (DIM_W+1)'(stride);
      step_x_s   = x_r;
      step_y_s   = y_r;
      step_idx_s = idx_r + IDX_W'(stride);
      if (sum_x_s >= {1'b0, width}) begin
         step_x_s = DIM_W'(sum_x_s - {1'b0, width});
         step_y_s = y_r + DIM_W'(1'b1);
      end else begin
         step_x_s = sum_x_s[DIM_W-1:0];
         step_y_s = y_r;
      end

      if (load) begin
         cand_x_s   = DIM_W'(load_x);
         cand_y_s   = {DIM_W{1'b0}};
         cand_idx_s = IDX_W'(load_x);
      end else begin
         cand_x_s   = step_x_s;
         cand_y_s   = step_y_s;
         cand_idx_s = step_idx_s;
      end

      last_sum_s  = {1'b0, cand_idx_s} + (IDX_W+1)'(stride);
      cand_last_s = (last_sum_s >= {1'b0, area});
   end

   // Pixel registers advance only when a new ray is presented.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         x_r    <= {DIM_W{1'b0}};
         y_r    <= {DIM_W{1'b0}};
         idx_r  <= {IDX_W{1'b0}};
         last_r <= 1'b0;
      end else if (load || step) begin
         x_r    <= cand_x_s;
         y_r    <= cand_y_s;
         idx_r  <= cand_idx_s;
         last_r <= cand_last_s;
      end
   end

   assign pix_x      = x_r;
   assign pix_y      = y_r;
   assign pix_index  = idx_r;
   assign pix_last   = last_r;
   assign cand_x     = cand_x_s;
   assign cand_y     = cand_y_s;
   assign cand_index = cand_idx_s;

endmodule

// File: rtl/ray_gen_stream.sv
// Per-core primary-ray generator. On start it latches the camera and image
// configuration, then streams camera-space ray directions for pixels
// core_id, core_id+num_cores, ... over a valid/ready interface at up to one
// ray per cycle. All stream outputs are registered; the ray for the next
// pixel is computed combinationally and loaded on the accepting edge.
module ray_gen_stream
   import ray_pkg::*;
#(
   parameter int VEC_W  = RAY_VEC_W,
   parameter int DIM_W  = 13,
   parameter int CORE_W = 4,
   parameter int DIR_W  = 32,
   parameter int IDX_W  = 2*DIM_W
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic                    abort,
   input  logic [CORE_W-1:0]       core_id,
   input  logic [CORE_W-1:0]       num_cores,
   input  logic [DIM_W-1:0]        image_width,
   input  logic [DIM_W-1:0]        image_height,
   input  logic signed [VEC_W-1:0] cam_dir_x,
   input  logic signed [VEC_W-1:0] cam_dir_y,
   input  logic signed [VEC_W-1:0] cam_dir_z,
   input  logic signed [VEC_W-1:0] cam_right_x,
   input  logic signed [VEC_W-1:0] cam_right_y,
   input  logic signed [VEC_W-1:0] cam_right_z,
   input  logic signed [VEC_W-1:0] cam_up_x,
   input  logic signed [VEC_W-1:0] cam_up_y,
   input  logic signed [VEC_W-1:0] cam_up_z,
   ray_gen_stream_if.master        ray_if,
   output logic                    busy,
   output logic                    done,
   output logic                    cfg_err
);

   // Control state and registered status outputs
   ray_state_e state_r, state_n;
   logic       ray_valid_r, valid_n;
   logic       busy_r;
   logic       done_r, done_n;
   logic       cfg_err_r, cfg_err_n;

   // Shadow configuration captured at start
   logic [CORE_W-1:0] nc_r;
   logic [DIM_W-1:0]  w_r;
   logic [DIM_W-1:0]  h_r;
   logic [IDX_W-1:0]  area_r;
   vec3_t             right_r, up_r, dir_r;

   // Registered ray direction
   logic signed [DIR_W-1:0] dir_x_r, dir_y_r, dir_z_r;

   // Combinational helpers
   logic              start_acc_s;
   logic              fire_s;
   logic              cfg_bad_s;
   logic              empty_s;
   logic              load_s;
   logic              step_s;
   logic [IDX_W-1:0]  area_in_s;
   vec3_t             in_right_s, in_up_s, in_dir_s;
   vec3_t             right_s, up_s, dir_s;
   logic [CORE_W-1:0] stride_s;
   logic [DIM_W-1:0]  width_s;
   logic [DIM_W-1:0]  height_s;
   logic [IDX_W-1:0]  area_s;
   logic [DIM_W-1:0]  half_w_s;
   logic [DIM_W-1:0]  half_h_s;
   logic signed [DIM_W:0] dx_s, dy_s;
   logic signed [RAY_OP_W-1:0] comp_x_s, comp_y_s, comp_z_s;

   // Stepper interface
   logic [DIM_W-1:0] pix_x_s, pix_y_s, cand_x_s, cand_y_s;
   logic [IDX_W-1:0] pix_idx_s, cand_idx_s;
   logic             pix_last_s;

   assign start_acc_s = (state_r == ST_IDLE) && start;
   assign fire_s      = ray_valid_r && ray_if.ray_ready;
   assign area_in_s   = IDX_W'(image_width) * IDX_W'(image_height);
   assign in_right_s  = '{x: cam_right_x, y: cam_right_y, z: cam_right_z};
   assign in_up_s     = '{x: cam_up_x,    y: cam_up_y,    z: cam_up_z};
   assign in_dir_s    = '{x: cam_dir_x,   y: cam_dir_y,   z: cam_dir_z};

   // Configuration checks on the live inputs, meaningful only with start in IDLE.
   always_comb begin
      cfg_bad_s = (num_cores == {CORE_W{1'b0}})
               || (DIM_W'(num_cores) > image_width)
               || (core_id >= num_cores)
               || (image_width == {DIM_W{1'b0}})
               || (image_height == {DIM_W{1'b0}});
      empty_s   = (IDX_W'(core_id) >= area_in_s);
   end

   // On the start edge the first ray uses the live inputs; afterwards the shadows.
   always_comb begin
      if (start_acc_s) begin
         right_s  = in_right_s;
         up_s     = in_up_s;
         dir_s    = in_dir_s;
         stride_s = num_cores;
         width_s  = image_width;
         height_s = image_height;
         area_s   = area_in_s;
      end else begin
         right_s  = right_r;
         up_s     = up_r;
         dir_s    = dir_r;
         stride_s = nc_r;
         width_s  = w_r;
         height_s = h_r;
         area_s   = area_r;
      end
   end

   ray_pixel_stepper #(
      .DIM_W  (DIM_W),
      .CORE_W (CORE_W),
      .IDX_W  (IDX_W)
   ) u_stepper (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (load_s),
      .step       (step_s),
      .load_x     (core_id),
      .stride     (stride_s),
      .width      (width_s),
      .area       (area_s),
      .pix_x      (pix_x_s),
      .pix_y      (pix_y_s),
      .pix_index  (pix_idx_s),
      .pix_last   (pix_last_s),
      .cand_x     (cand_x_s),
      .cand_y     (cand_y_s),
      .cand_index (cand_idx_s)
   );

   // Centre-relative offsets and per-axis multiply-add for the candidate pixel.
   always_comb begin
      half_w_s = width_s >> 1;
      half_h_s = height_s >> 1;
      dx_s     = $signed({1'b0, cand_x_s}) - $signed({1'b0, half_w_s});
      dy_s     = $signed({1'b0, half_h_s}) - $signed({1'b0, cand_y_s});
      comp_x_s = ray_dir_comp(RAY_OP_W'(right_s.x), RAY_OP_W'(up_s.x),
                              RAY_OP_W'(dir_s.x), RAY_OP_W'(dx_s), RAY_OP_W'(dy_s));
      comp_y_s = ray_dir_comp(RAY_OP_W'(right_s.y), RAY_OP_W'(up_s.y),
                              RAY_OP_W'(dir_s.y), RAY_OP_W'(dx_s), RAY_OP_W'(dy_s));
      comp_z_s = ray_dir_comp(RAY_OP_W'(right_s.z), RAY_OP_W'(up_s.z),
                              RAY_OP_W'(dir_s.z), RAY_OP_W'(dx_s), RAY_OP_W'(dy_s));
   end

   // Next-state and control decode; abort takes priority over an accepted ray.
   always_comb begin
      state_n   = state_r;
      valid_n   = ray_valid_r;
      done_n    = 1'b0;
      cfg_err_n = cfg_err_r;
      load_s    = 1'b0;
      step_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            valid_n = 1'b0;
            if (start) begin
               if (cfg_bad_s) begin
                  cfg_err_n = 1'b1;
                  done_n    = 1'b1;
               end else if (empty_s) begin
                  cfg_err_n = 1'b0;
                  done_n    = 1'b1;
               end else begin
                  cfg_err_n = 1'b0;
                  load_s    = 1'b1;
                  valid_n   = 1'b1;
                  state_n   = ST_RUN;
               end
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_n = ST_IDLE;
               valid_n = 1'b0;
            end else if (fire_s && pix_last_s) begin
               state_n = ST_IDLE;
               valid_n = 1'b0;
               done_n  = 1'b1;
            end else if (fire_s) begin
               step_s = 1'b1;
            end else begin
               state_n = ST_RUN;
            end
         end
         default: begin
            state_n = ST_IDLE;
            valid_n = 1'b0;
         end
      endcase
   end

   // State and registered status outputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r     <= ST_IDLE;
         ray_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         cfg_err_r   <= 1'b0;
      end else begin
         state_r     <= state_n;
         ray_valid_r <= valid_n;
         busy_r      <= (state_n == ST_RUN);
         done_r      <= done_n;
         cfg_err_r   <= cfg_err_n;
      end
   end

   // Shadow copies of configuration and camera, captured only on an accepted start.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         nc_r    <= {CORE_W{1'b0}};
         w_r     <= {DIM_W{1'b0}};
         h_r     <= {DIM_W{1'b0}};
         area_r  <= {IDX_W{1'b0}};
         right_r <= '0;
         up_r    <= '0;
         dir_r   <= '0;
      end else if (start_acc_s) begin
         nc_r    <= num_cores;
         w_r     <= image_width;
         h_r     <= image_height;
         area_r  <= area_in_s;
         right_r <= in_right_s;
         up_r    <= in_up_s;
         dir_r   <= in_dir_s;
      end
   end

   // Ray direction registers load together with the stepper's pixel registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         dir_x_r <= {DIR_W{1'b0}};
         dir_y_r <= {DIR_W{1'b0}};
         dir_z_r <= {DIR_W{1'b0}};
      end else if (load_s || step_s) begin
         dir_x_r <= DIR_W'(comp_x_s);
         dir_y_r <= DIR_W'(comp_y_s);
         dir_z_r <= DIR_W'(comp_z_s);
      end
   end

   assign ray_if.ray_valid = ray_valid_r;
   assign ray_if.ray_dir_x = dir_x_r;
   assign ray_if.ray_dir_y = dir_y_r;
   assign ray_if.ray_dir_z = dir_z_r;
   assign ray_if.pix_x     = pix_x_s;
   assign ray_if.pix_y     = pix_y_s;
   assign ray_if.pix_index = pix_idx_s;
   assign ray_if.ray_last  = pix_last_s;
   assign busy             = busy_r;
   assign done             = done_r;
   assign cfg_err          = cfg_err_r;

endmodule

// File: tb/tb_ray_gen_stream.sv
// Directed testbench for ray_gen_stream with hand-computed expected rays.
module tb_ray_gen_stream;

   localparam int VEC_W  = 11;
   localparam int DIM_W  = 13;
   localparam int CORE_W = 4;
   localparam int DIR_W  = 32;
   localparam int IDX_W  = 2*DIM_W;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                    reset_n;
   logic                    start;
   logic                    abort;
   logic [CORE_W-1:0]       core_id;
   logic [CORE_W-1:0]       num_cores;
   logic [DIM_W-1:0]        image_width;
   logic [DIM_W-1:0]        image_height;
   logic signed [VEC_W-1:0] cam_dir_x, cam_dir_y, cam_dir_z;
   logic signed [VEC_W-1:0] cam_right_x, cam_right_y, cam_right_z;
   logic signed [VEC_W-1:0] cam_up_x, cam_up_y, cam_up_z;
   logic                    busy, done, cfg_err;

   ray_gen_stream_if #(.DIM_W(DIM_W), .DIR_W(DIR_W), .IDX_W(IDX_W)) rif ();

   ray_gen_stream #(
      .VEC_W(VEC_W), .DIM_W(DIM_W), .CORE_W(CORE_W), .DIR_W(DIR_W), .IDX_W(IDX_W)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .abort        (abort),
      .core_id      (core_id),
      .num_cores    (num_cores),
      .image_width  (image_width),
      .image_height (image_height),
      .cam_dir_x    (cam_dir_x),
      .cam_dir_y    (cam_dir_y),
      .cam_dir_z    (cam_dir_z),
      .cam_right_x  (cam_right_x),
      .cam_right_y  (cam_right_y),
      .cam_right_z  (cam_right_z),
      .cam_up_x     (cam_up_x),
      .cam_up_y     (cam_up_y),
      .cam_up_z     (cam_up_z),
      .ray_if       (rif),
      .busy         (busy),
      .done         (done),
      .cfg_err      (cfg_err)
   );

   int chk_total = 0;
   int chk_pass  = 0;

   task automatic check_val(input string tag, input longint obs, input longint exp);
      chk_total++;
      if (obs == exp) chk_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cfg(input int cid, input int nc, input int w, input int h);
      core_id      = CORE_W'(cid);
      num_cores    = CORE_W'(nc);
      image_width  = DIM_W'(w);
      image_height = DIM_W'(h);
   endtask

   task automatic set_cam(input int rx, input int ry, input int rz,
                          input int ux, input int uy, input int uz,
                          input int dx, input int dy, input int dz);
      cam_right_x = VEC_W'(rx); cam_right_y = VEC_W'(ry); cam_right_z = VEC_W'(rz);
      cam_up_x    = VEC_W'(ux); cam_up_y    = VEC_W'(uy); cam_up_z    = VEC_W'(uz);
      cam_dir_x   = VEC_W'(dx); cam_dir_y   = VEC_W'(dy); cam_dir_z   = VEC_W'(dz);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic check_ray(input string tag, input int x, input int y, input int idx,
                            input int ex, input int ey, input int ez, input int last);
      check_val({tag, "_valid"}, rif.ray_valid, 1);
      check_val({tag, "_x"},     rif.pix_x, x);
      check_val({tag, "_y"},     rif.pix_y, y);
      check_val({tag, "_idx"},   rif.pix_index, idx);
      check_val({tag, "_dx"},    rif.ray_dir_x, ex);
      check_val({tag, "_dy"},    rif.ray_dir_y, ey);
      check_val({tag, "_dz"},    rif.ray_dir_z, ez);
      check_val({tag, "_last"},  rif.ray_last, last);
   endtask

   task automatic check_zero_outputs(input string tag);
      check_val({tag, "_valid"}, rif.ray_valid, 0);
      check_val({tag, "_pix"},   {rif.pix_x, rif.pix_y}, 0);
      check_val({tag, "_idx"},   rif.pix_index, 0);
      check_val({tag, "_dir"},   (rif.ray_dir_x != 0) || (rif.ray_dir_y != 0) || (rif.ray_dir_z != 0), 0);
      check_val({tag, "_last"},  rif.ray_last, 0);
      check_val({tag, "_busy"},  busy, 0);
      check_val({tag, "_done"},  done, 0);
      check_val({tag, "_err"},   cfg_err, 0);
   endtask

   logic [3:0] rdy_pat;
   int         exp_i;
   bit         fin;
   bit         rdy;

   initial begin
      reset_n = 1'b0; start = 1'b0; abort = 1'b0;
      rif.ray_ready = 1'b0;
      set_cfg(0, 0, 0, 0);
      set_cam(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick(); tick();
      reset_n = 1'b1;
      check_zero_outputs("rst");

      // Scenario 1: full frame, one core, 4x2. dx = x-2, dy = 1-y.
      set_cfg(0, 1, 4, 2);
      set_cam(1, 0, 0, 0, 1, 0, 0, 0, 5);
      rif.ray_ready = 1'b1;
      pulse_start();
      for (int i = 0; i < 8; i++) begin
         check_ray($sformatf("s1_p%0d", i), i % 4, i / 4, i, (i % 4) - 2, 1 - (i / 4), 5, (i == 7) ? 1 : 0);
         check_val($sformatf("s1_busy%0d", i), busy, 1);
         check_val($sformatf("s1_nodone%0d", i), done, 0);
         tick();
      end
      check_val("s1_end_valid", rif.ray_valid, 0);
      check_val("s1_end_done", done, 1);
      check_val("s1_end_busy", busy, 0);
      tick();
      check_val("s1_done_pulse", done, 0);

      // Scenario 2: interleave, width 5, 4 cores, core 3.
      set_cfg(3, 4, 5, 3);
      set_cam(2, 0, 1, 0, 3, 0, 1, -1, 7);
      pulse_start();
      check_ray("s2_i3", 3, 0, 3, 3, 2, 8, 0);
      tick();
      check_ray("s2_i7", 2, 1, 7, 1, -1, 7, 0);
      tick();
      check_ray("s2_i11", 1, 2, 11, -1, -4, 6, 1);
      tick();
      check_val("s2_end_valid", rif.ray_valid, 0);
      check_val("s2_end_done", done, 1);

      // Scenario 3: scenario 1 with ready pattern 1,0,0,1.
      set_cfg(0, 1, 4, 2);
      set_cam(1, 0, 0, 0, 1, 0, 0, 0, 5);
      rdy_pat = 4'b1001;
      exp_i = 0;
      fin = 1'b0;
      pulse_start();
      for (int c = 0; c < 64 && !fin; c++) begin
         check_val($sformatf("s3_c%0d_valid", c), rif.ray_valid, 1);
         check_val($sformatf("s3_c%0d_idx", c), rif.pix_index, exp_i);
         check_val($sformatf("s3_c%0d_x", c), rif.pix_x, exp_i % 4);
         check_val($sformatf("s3_c%0d_dx", c), rif.ray_dir_x, (exp_i % 4) - 2);
         check_val($sformatf("s3_c%0d_dy", c), rif.ray_dir_y, 1 - (exp_i / 4));
         rdy = rdy_pat[c % 4];
         rif.ray_ready = rdy;
         tick();
         if (rdy) begin
            if (exp_i == 7) fin = 1'b1;
            else exp_i++;
         end
      end
      check_val("s3_done", done, 1);
      check_val("s3_end_valid", rif.ray_valid, 0);
      rif.ray_ready = 1'b1;

      // Scenario 4: configuration errors.
      set_cfg(0, 6, 4, 2);
      pulse_start();
      check_val("s4a_err", cfg_err, 1);
      check_val("s4a_done", done, 1);
      check_val("s4a_valid", rif.ray_valid, 0);
      check_val("s4a_busy", busy, 0);
      tick();
      check_val("s4a_err_sticky", cfg_err, 1);
      check_val("s4a_done_pulse", done, 0);
      check_val("s4a_valid2", rif.ray_valid, 0);
      set_cfg(2, 3, 1, 1);
      pulse_start();
      check_val("s4b_err", cfg_err, 1);
      check_val("s4b_done", done, 1);
      check_val("s4b_valid", rif.ray_valid, 0);
      tick();
      check_val("s4b_valid2", rif.ray_valid, 0);

      // Scenario 5: abort on the third ray, then restart.
      set_cfg(0, 1, 4, 2);
      pulse_start();
      check_val("s5_err_cleared", cfg_err, 0);
      tick(); tick();
      check_val("s5_third_idx", rif.pix_index, 2);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_val("s5_abort_valid", rif.ray_valid, 0);
      check_val("s5_abort_busy", busy, 0);
      check_val("s5_abort_done", done, 0);
      tick();
      check_val("s5_abort_nodone", done, 0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_val("s5_idle_abort_valid", rif.ray_valid, 0);
      pulse_start();
      check_ray("s5_restart", 0, 0, 0, -2, 1, 5, 0);

      // Scenario 6: start ignored in RUN, then reset mid-RUN.
      rif.ray_ready = 1'b0;
      set_cfg(1, 2, 4, 2);
      start = 1'b1;
      tick();
      start = 1'b0;
      check_val("s6_run_start_idx", rif.pix_index, 0);
      check_val("s6_run_start_valid", rif.ray_valid, 1);
      rif.ray_ready = 1'b1;
      tick();
      check_ray("s6_next", 1, 0, 1, -1, 1, 5, 0);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      check_zero_outputs("s6_rst");
      tick();
      check_val("s6_idle_valid", rif.ray_valid, 0);
      check_val("s6_idle_busy", busy, 0);

      $display("%0d/%0d checks passed", chk_pass, chk_total);
      $finish;
   end

endmodule
